seg7_scan_driver: RTL and testbench

- Downstream consumer of the view-mode controller. Drives the board's 4-digit common-anode 7-segment display from a 6-digit result window (d0..d5, where d5 carries the sign).
- view_mode selects which 4 consecutive digits are shown.
- Time-multiplexes the anodes with a refresh counter and blanks between digit switches to prevent ghosting.
- Takes a frame-coherent snapshot of the inputs so a display frame never tears.

---
 rtl/seg7_defs_pkg.sv | 36 +++
 rtl/seg7_decode.sv | 29 ++
 rtl/seg7_scan_driver.sv | 98 +++++++++
 tb/tb_seg7_scan_driver.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seg7_defs_pkg.sv
// Shared definitions for the 7-segment display path: digit codes,
// active-low segment patterns (gfedcba) and view_mode encodings.
package seg7_defs_pkg;

  // Special digit codes carried alongside 0..9.
  localparam logic [3:0] DIGIT_MINUS = 4'hA;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Window selection shared with the view-mode controller.
  typedef enum logic [1:0] {
    VIEW_LOW      = 2'b00,  // d0..d3
    VIEW_MID      = 2'b01,  // d1..d4
    VIEW_HIGH     = 2'b10,  // d2..d5
    VIEW_HIGH_ALT = 2'b11   // aliases VIEW_HIGH
  } view_mode_e;

  // Fold the alias encoding onto VIEW_HIGH so the window never runs past d5.
  function automatic logic [1:0] clamp_view(input logic [1:0] mode);
    return (mode == VIEW_HIGH_ALT) ? VIEW_HIGH : mode;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low 7-segment pattern decoder.
module seg7_decode
  import seg7_defs_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  // Map each code to its pattern; unused codes light nothing.
  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    seg_o = SEG_BLANK;
    unique case (code_i)
      4'd0:        seg_o = SEG_0;
      4'd1:        seg_o = SEG_1;
      4'd2:        seg_o = SEG_2;
      4'd3:        seg_o = SEG_3;
      4'd4:        seg_o = SEG_4;
      4'd5:        seg_o = SEG_5;
      4'd6:        seg_o = SEG_6;
      4'd7:        seg_o = SEG_7;
      4'd8:        seg_o = SEG_8;
      4'd9:        seg_o = SEG_9;
      DIGIT_MINUS: seg_o = SEG_MINUS;
      default:     seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver showing a 4-digit window of a
// 6-digit value. Inputs are snapshotted once per frame so a frame never
// tears, and each digit slot begins with a short all-off blanking gap.
module seg7_scan_driver
  import seg7_defs_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] digits,
  input  logic [1:0]  view_mode,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pos_q, pos_d;
  logic [23:0]      snap_digits_q;
  logic [1:0]       snap_view_q;
  logic             frame_start;

  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic [2:0]       digit_idx;
  logic [3:0]       cur_code;
  logic [6:0]       cur_seg;

  assign frame_start = (cnt_q == '0) && (pos_q == 2'd0);

  // Pick the digit for the current slot out of the frozen window.
  assign digit_idx = {1'b0, snap_view_q} + {1'b0, pos_q};
  assign cur_code  = snap_digits_q[{digit_idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .code_i (cur_code),
    .seg_o  (cur_seg)
  );

  // Slot counter and position advance, plus next output values.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    pos_d = pos_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      pos_d = pos_q + 2'd1;
    end

    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (cnt_q >= CNT_BLANK) begin
      an_d  = ~(4'b0001 << pos_q);
      seg_d = cur_seg;
      // Scroll hints: pos3 dot means more digits to the left, pos0 to the right.
      if ((pos_q == 2'd3 && snap_view_q < VIEW_HIGH) ||
          (pos_q == 2'd0 && snap_view_q > VIEW_LOW))
        dp_d = 1'b0;
    end
  end

  // Registered state: counters, frame snapshot and display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      pos_q         <= 2'd0;
      snap_digits_q <= '0;
      snap_view_q   <= VIEW_LOW;
      an_q          <= 4'b1111;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      if (frame_start) begin
        snap_digits_q <= digits;
        snap_view_q   <= clamp_view(view_mode);
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, BLANK_CYC=1.
// Expected per-cycle outputs are queued as stimulus is applied and popped
// one entry per clock edge.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [23:0] digits;
  logic [1:0]  view_mode;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];

  seg7_scan_driver #(
    .REFRESH_DIV (4),
    .BLANK_CYC   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits    (digits),
    .view_mode (view_mode),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference segment table, written out from the display datasheet patterns.
  function automatic logic [6:0] ref_seg(input logic [3:0] code);
    case (code)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_blank();
    exp_t e;
    e.an  = 4'b1111;
    e.seg = 7'b1111111;
    e.dp  = 1'b1;
    sb.push_back(e);
  endtask

  // Queue one full frame (4 slots x 4 cycles) for a given snapshot.
  task automatic push_frame(input logic [23:0] d, input int v);
    exp_t e;
    logic [3:0] code;
    for (int slot = 0; slot < 4; slot++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) begin
          push_blank();
        end else begin
          code  = d[(v + slot) * 4 +: 4];
          e.an  = ~(4'b0001 << slot);
          e.seg = ref_seg(code);
          e.dp  = !((slot == 3 && v < 2) || (slot == 0 && v > 0));
          sb.push_back(e);
        end
      end
    end
  endtask

  // Advance one edge and compare the DUT outputs against the queue head.
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "/an"},  {3'b000, an},  {3'b000, e.an});
      check({tag, "/seg"}, seg,           e.seg);
      check({tag, "/dp"},  {6'd0, dp},    {6'd0, e.dp});
      check({tag, "/anodes_low_le1"}, {6'd0, ($countones(~an) <= 1)}, 7'd1);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    rst       = 1'b1;
    digits    = 24'h0;
    view_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset/an",  {3'b000, an}, 7'b0001111);
    check("reset/seg", seg,          7'b1111111);
    check("reset/dp",  {6'd0, dp},   7'd1);

    // Scenario 1: view 00 on A12345.
    digits = 24'hA12345; view_mode = 2'b00; rst = 1'b0;
    push_frame(24'hA12345, 0); run(16, "view00");

    // Scenario 2: view 10, then alias 11 gives the same window.
    view_mode = 2'b10;
    push_frame(24'hA12345, 2); run(16, "view10");
    view_mode = 2'b11;
    push_frame(24'hA12345, 2); run(16, "view11");

    // Scenario 3: view 01.
    view_mode = 2'b01;
    push_frame(24'hA12345, 1); run(16, "view01");

    // Scenario 4: mid-frame digits change is deferred to the next frame.
    view_mode = 2'b00;
    push_frame(24'hA12345, 0); run(6, "midd_old");
    digits = 24'h000000;       run(10, "midd_old");
    push_frame(24'h000000, 0); run(16, "midd_new");

    // Mid-frame view change is deferred the same way.
    digits = 24'hA12345;
    push_frame(24'hA12345, 0); run(6, "midv_old");
    view_mode = 2'b10;         run(10, "midv_old");
    push_frame(24'hA12345, 2); run(16, "midv_new");

    // Scenario 5: reset at pos=2, cnt=3 abandons the frame.
    view_mode = 2'b00;
    push_frame(24'hA12345, 0); run(11, "rst_pre");
    sb.delete();
    rst = 1'b1; digits = 24'h987654; view_mode = 2'b01;
    push_blank(); step("rst_edge");
    rst = 1'b0;
    push_frame(24'h987654, 1); run(16, "rst_post");

    // Scenario 6: blank codes keep their anode driven.
    digits = 24'h000FCB; view_mode = 2'b00;
    push_frame(24'h000FCB, 0); run(16, "blankcodes");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
